// File: rtl/cacheline_arbiter.sv
// Two-to-one arbiter sharing one cacheline adapter between the I-cache and D-cache.
// Define ARBITER_RR_EN for round-robin ties; otherwise the D-cache always wins a tie.
module cacheline_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] icache_address_i,
  input  logic              icache_read_i,
  input  logic              icache_write_i,
  input  logic [LINE_W-1:0] icache_line_i,
  output logic [LINE_W-1:0] icache_line_o,
  output logic              icache_resp_o,

  input  logic [ADDR_W-1:0] dcache_address_i,
  input  logic              dcache_read_i,
  input  logic              dcache_write_i,
  input  logic [LINE_W-1:0] dcache_line_i,
  output logic [LINE_W-1:0] dcache_line_o,
  output logic              dcache_resp_o,

  output logic [ADDR_W-1:0] adapter_address_o,
  output logic              adapter_read_o,
  output logic              adapter_write_o,
  output logic [LINE_W-1:0] adapter_line_o,
  input  logic [LINE_W-1:0] adapter_line_i,
  input  logic              adapter_resp_i,

  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] grant_q;
  logic [1:0] grant_next;
  logic       i_req;
  logic       d_req;
  logic       pick_d;

  assign i_req = icache_read_i | icache_write_i;
  assign d_req = dcache_read_i | dcache_write_i;

`ifdef ARBITER_RR_EN
  // Remembers which port was granted most recently; starts as "D-cache" so the
  // first tie after reset goes to the I-cache.
  logic last_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_d <= 1'b1;
    end else if (state == IDLE) begin
      if (state_next == GRANT_D) begin
        last_d <= 1'b1;
      end else if (state_next == GRANT_I) begin
        last_d <= 1'b0;
      end
    end
  end

  assign pick_d = d_req & (~i_req | ~last_d);
`else
  assign pick_d = d_req;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      grant_q <= 2'b00;
    end else begin
      state   <= state_next;
      grant_q <= grant_next;
    end
  end

  // NOTE: each combinational output gets a default before the case so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_next = GRANT_D;
        end else if (i_req) begin
          state_next = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (adapter_resp_i) begin
          state_next = GAP;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // grant_o is registered alongside the state so it always reflects the current grant.
  always_comb begin
    grant_next = 2'b00;
    case (state_next)
      GRANT_I: grant_next = 2'b01;
      GRANT_D: grant_next = 2'b10;
      default: grant_next = 2'b00;
    endcase
  end

  always_comb begin
    adapter_address_o = '0;
    adapter_line_o    = '0;
    adapter_read_o    = 1'b0;
    adapter_write_o   = 1'b0;
    icache_resp_o     = 1'b0;
    dcache_resp_o     = 1'b0;
    case (state)
      GRANT_I: begin
        adapter_address_o = icache_address_i;
        adapter_line_o    = icache_line_i;
        adapter_read_o    = icache_read_i;
        adapter_write_o   = icache_write_i & ~icache_read_i;
        icache_resp_o     = adapter_resp_i;
      end
      GRANT_D: begin
        adapter_address_o = dcache_address_i;
        adapter_line_o    = dcache_line_i;
        adapter_read_o    = dcache_read_i;
        adapter_write_o   = dcache_write_i & ~dcache_read_i;
        dcache_resp_o     = adapter_resp_i;
      end
      default: begin
      end
    endcase
  end

  // Fill data is broadcast; only the resp pulse tells a cache the line is its own.
  assign icache_line_o = adapter_line_i;
  assign dcache_line_o = adapter_line_i;
  assign grant_o       = grant_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Randomized self-checking bench for cacheline_arbiter against a cycle-level
// ownership model; honours ARBITER_RR_EN the same way as the design.
module tb_cacheline_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] icache_address_i;
  logic              icache_read_i;
  logic              icache_write_i;
  logic [LINE_W-1:0] icache_line_i;
  logic [LINE_W-1:0] icache_line_o;
  logic              icache_resp_o;
  logic [ADDR_W-1:0] dcache_address_i;
  logic              dcache_read_i;
  logic              dcache_write_i;
  logic [LINE_W-1:0] dcache_line_i;
  logic [LINE_W-1:0] dcache_line_o;
  logic              dcache_resp_o;
  logic [ADDR_W-1:0] adapter_address_o;
  logic              adapter_read_o;
  logic              adapter_write_o;
  logic [LINE_W-1:0] adapter_line_o;
  logic [LINE_W-1:0] adapter_line_i;
  logic              adapter_resp_i;
  logic [1:0]        grant_o;

  always #5 clk = ~clk;

  cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .icache_address_i  (icache_address_i),
    .icache_read_i     (icache_read_i),
    .icache_write_i    (icache_write_i),
    .icache_line_i     (icache_line_i),
    .icache_line_o     (icache_line_o),
    .icache_resp_o     (icache_resp_o),
    .dcache_address_i  (dcache_address_i),
    .dcache_read_i     (dcache_read_i),
    .dcache_write_i    (dcache_write_i),
    .dcache_line_i     (dcache_line_i),
    .dcache_line_o     (dcache_line_o),
    .dcache_resp_o     (dcache_resp_o),
    .adapter_address_o (adapter_address_o),
    .adapter_read_o    (adapter_read_o),
    .adapter_write_o   (adapter_write_o),
    .adapter_line_o    (adapter_line_o),
    .adapter_line_i    (adapter_line_i),
    .adapter_resp_i    (adapter_resp_i),
    .grant_o           (grant_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: who owns the adapter and how many quiet cycles remain
  // before the next arbitration is allowed.
  int          m_owner;   // 0 none, 1 I-cache, 2 D-cache
  int          m_quiet;
`ifdef ARBITER_RR_EN
  bit          m_last_d;
`endif
  logic        e_rd, e_wr, e_ir, e_dr, m_ireq, m_dreq;
  logic [ADDR_W-1:0] e_addr;
  logic [LINE_W-1:0] e_line;
  logic [1:0]  prev_grant;
  int          dut_served[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      m_owner    = 0;
      m_quiet    = 0;
`ifdef ARBITER_RR_EN
      m_last_d   = 1'b1;
`endif
      prev_grant = 2'b00;
      check("rst_grant", 256'(grant_o), 256'(0));
      check("rst_adapter_read", 256'(adapter_read_o), 256'(0));
      check("rst_adapter_write", 256'(adapter_write_o), 256'(0));
      check("rst_icache_resp", 256'(icache_resp_o), 256'(0));
      check("rst_dcache_resp", 256'(dcache_resp_o), 256'(0));
    end else begin
      e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_addr = '0; e_line = '0;
      if (m_owner == 1) begin
        e_rd = icache_read_i; e_wr = icache_write_i & ~icache_read_i;
        e_addr = icache_address_i; e_line = icache_line_i; e_ir = adapter_resp_i;
      end else if (m_owner == 2) begin
        e_rd = dcache_read_i; e_wr = dcache_write_i & ~dcache_read_i;
        e_addr = dcache_address_i; e_line = dcache_line_i; e_dr = adapter_resp_i;
      end
      check("grant", 256'(grant_o), 256'(m_owner));
      check("adapter_read", 256'(adapter_read_o), 256'(e_rd));
      check("adapter_write", 256'(adapter_write_o), 256'(e_wr));
      check("icache_resp", 256'(icache_resp_o), 256'(e_ir));
      check("dcache_resp", 256'(dcache_resp_o), 256'(e_dr));
      check("icache_line", icache_line_o, adapter_line_i);
      check("dcache_line", dcache_line_o, adapter_line_i);
      if (m_owner != 0) begin
        check("adapter_address", 256'(adapter_address_o), 256'(e_addr));
        check("adapter_line", adapter_line_o, e_line);
      end
      if (grant_o != 2'b00 && prev_grant == 2'b00) dut_served.push_back(int'(grant_o));
      prev_grant = grant_o;

      m_ireq = icache_read_i | icache_write_i;
      m_dreq = dcache_read_i | dcache_write_i;
      if (m_owner != 0) begin
        if (adapter_resp_i) begin
          m_owner = 0;
          m_quiet = 1;
        end
      end else if (m_quiet > 0) begin
        m_quiet--;
      end else if (m_ireq || m_dreq) begin
        if (m_ireq && m_dreq) begin
`ifdef ARBITER_RR_EN
          m_owner = m_last_d ? 1 : 2;
`else
          m_owner = 2;
`endif
        end else begin
          m_owner = m_ireq ? 1 : 2;
        end
`ifdef ARBITER_RR_EN
        m_last_d = (m_owner == 2);
`endif
      end
    end
  end

  // Stimulus side: cache requesters and a behavioural adapter, all driven from one process.
  bit i_fin, d_fin, a_seen, a_busy, a_hold, i_keep, d_keep, rand_mode;
  int a_lat;

  task automatic tick();
    int k;
    @(negedge clk);
    i_fin  = icache_resp_o;
    d_fin  = dcache_resp_o;
    a_seen = adapter_read_o | adapter_write_o;
    @(posedge clk);
    #1;
    adapter_line_i = rand_line();
    if (adapter_resp_i) begin
      adapter_resp_i = 1'b0;
    end else if (a_busy && !a_hold) begin
      if (a_lat == 0) begin
        adapter_resp_i = 1'b1;
        a_busy = 1'b0;
      end else begin
        a_lat--;
      end
    end else if (a_seen && !a_busy) begin
      a_busy = 1'b1;
      a_lat  = $urandom_range(0, 3);
    end
    if (i_fin) begin
      if (!i_keep) begin icache_read_i = 1'b0; icache_write_i = 1'b0; end
      else if (rand_mode) i_keep = ($urandom_range(0, 3) == 0);
    end
    if (d_fin) begin
      if (!d_keep) begin dcache_read_i = 1'b0; dcache_write_i = 1'b0; end
      else if (rand_mode) d_keep = ($urandom_range(0, 3) == 0);
    end
    if (rand_mode) begin
      if (!(icache_read_i | icache_write_i)) begin
        icache_address_i = $urandom;
        icache_line_i    = rand_line();
        if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, 2);
          icache_read_i  = (k != 1);
          icache_write_i = (k != 0);
          i_keep = ($urandom_range(0, 3) == 0);
        end
      end
      if (!(dcache_read_i | dcache_write_i)) begin
        dcache_address_i = $urandom;
        dcache_line_i    = rand_line();
        if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, 2);
          dcache_read_i  = (k != 1);
          dcache_write_i = (k != 0);
          d_keep = ($urandom_range(0, 3) == 0);
        end
      end
    end
  endtask

  task automatic set_i(input logic [ADDR_W-1:0] a, input logic rd, input logic wr, input logic [LINE_W-1:0] l);
    icache_address_i = a; icache_read_i = rd; icache_write_i = wr; icache_line_i = l;
  endtask

  task automatic set_d(input logic [ADDR_W-1:0] a, input logic rd, input logic wr, input logic [LINE_W-1:0] l);
    dcache_address_i = a; dcache_read_i = rd; dcache_write_i = wr; dcache_line_i = l;
  endtask

  task automatic wait_served(input int n, input int budget);
    int c = 0;
    while (dut_served.size() < n && c < budget) begin tick(); c++; end
    check("served_count", 256'(dut_served.size()), 256'(n));
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((icache_read_i | icache_write_i | dcache_read_i | dcache_write_i | (grant_o != 2'b00))
           && c < budget) begin
      tick(); c++;
    end
    check("drain_timeout", 256'(c < budget), 256'(1));
    tick(); tick();
  endtask

  task automatic check_order(input string tag, input int base, input int first, input int second);
    if (dut_served.size() >= base + 2) begin
      check({tag, "_first"}, 256'(dut_served[base]), 256'(first));
      check({tag, "_second"}, 256'(dut_served[base + 1]), 256'(second));
    end else begin
      check({tag, "_count"}, 256'(dut_served.size()), 256'(base + 2));
    end
  endtask

  int base;
  int c;
  int tie_first, tie_second;

  initial begin
    reset_n = 1'b0;
    set_i('0, 1'b0, 1'b0, '0);
    set_d('0, 1'b0, 1'b0, '0);
    adapter_line_i = '0; adapter_resp_i = 1'b0;
    a_busy = 0; a_hold = 0; a_lat = 0; i_keep = 0; d_keep = 0; rand_mode = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick(); tick();

    // First simultaneous pair after reset.
`ifdef ARBITER_RR_EN
    tie_first = 1; tie_second = 2;
`else
    tie_first = 2; tie_second = 1;
`endif
    base = dut_served.size();
    set_i(32'h0000_2000, 1'b1, 1'b0, rand_line());
    set_d(32'h0000_3000, 1'b1, 1'b0, rand_line());
    wait_served(base + 2, 60);
    check_order("pair_a", base, tie_first, tie_second);
    wait_idle(60);

    // Lone D-cache write of an A5 line.
    base = dut_served.size();
    set_d(32'h8000_0040, 1'b0, 1'b1, {8{32'hA5A5_A5A5}});
    wait_served(base + 1, 20);
    if (dut_served.size() > base) check("lone_d", 256'(dut_served[base]), 256'(2));
    wait_idle(40);

    // Lone I-cache read at 0x1000.
    base = dut_served.size();
    set_i(32'h0000_1000, 1'b1, 1'b0, rand_line());
    wait_served(base + 1, 20);
    if (dut_served.size() > base) check("lone_i", 256'(dut_served[base]), 256'(1));
    wait_idle(40);

    // Second pair, I-cache served last: D wins in both modes.
    base = dut_served.size();
    set_i(32'h0000_5000, 1'b1, 1'b0, rand_line());
    set_d(32'h0000_6000, 1'b0, 1'b1, rand_line());
    wait_served(base + 2, 60);
    check_order("pair_b", base, 2, 1);
    wait_idle(60);

    // D-cache holds read across two back-to-back misses.
    base = dut_served.size();
    d_keep = 1;
    set_d(32'h0000_7700, 1'b1, 1'b0, rand_line());
    wait_served(base + 2, 60);
    d_keep = 0;
    check_order("b2b_d", base, 2, 2);
    wait_idle(40);

    // Read and write asserted together: read wins.
    base = dut_served.size();
    set_i(32'h0000_8800, 1'b1, 1'b1, rand_line());
    wait_served(base + 1, 20);
    check("rw_read", 256'(adapter_read_o), 256'(1));
    check("rw_write", 256'(adapter_write_o), 256'(0));
    wait_idle(40);

    // Asynchronous reset two cycles into a D-cache read grant.
    a_hold = 1;
    set_d(32'h0000_4440, 1'b1, 1'b0, rand_line());
    c = 0;
    while (grant_o != 2'b10 && c < 20) begin tick(); c++; end
    check("rst_pre_grant", 256'(grant_o), 256'(2));
    tick(); tick();
    #3 reset_n = 1'b0;
    set_d('0, 1'b0, 1'b0, '0);
    set_i(32'h0000_9000, 1'b1, 1'b0, rand_line());
    adapter_resp_i = 1'b0; a_busy = 0; a_hold = 0;
    #1;
    check("async_grant", 256'(grant_o), 256'(0));
    check("async_read", 256'(adapter_read_o), 256'(0));
    check("async_write", 256'(adapter_write_o), 256'(0));
    check("async_dresp", 256'(dcache_resp_o), 256'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    base = dut_served.size();
    wait_served(base + 1, 20);
    if (dut_served.size() > base) check("post_rst_i", 256'(dut_served[base]), 256'(1));
    wait_idle(40);

    // Randomized traffic.
    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0; i_keep = 0; d_keep = 0;
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Two-to-one arbiter that shares the single cacheline adapter, the 256-bit line to 64-bit burst converter, between the instruction cache and the data cache. It sits between both caches' LLC-side miss ports and the adapter's LLC port. It grants one requester at a time, steers address, data and read/write to the adapter, and routes the adapter's one-cycle response back to the granted cache only. It also inserts a mandatory idle cycle between transactions so the adapter is never re-triggered by a stale request.

## Interface
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, address width in bits

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- icache_address_i  in  ADDR_W  I-cache miss address
- icache_read_i  in  1  I-cache read request, level, held until icache_resp_o
- icache_write_i  in  1  I-cache write request, level, held until icache_resp_o
- icache_line_i  in  LINE_W  I-cache writeback line
- icache_line_o  out  LINE_W  fill line, valid when icache_resp_o=1
- icache_resp_o  out  1  one-cycle completion pulse to I-cache
- dcache_address_i, dcache_read_i, dcache_write_i, dcache_line_i, dcache_line_o, dcache_resp_o  same as the icache_* ports, for the D-cache
- adapter_address_o  out  ADDR_W  address to adapter
- adapter_read_o  out  1  read request to adapter
- adapter_write_o  out  1  write request to adapter
- adapter_line_o  out  LINE_W  writeback line to adapter
- adapter_line_i  in  LINE_W  fill line from adapter
- adapter_resp_i  in  1  adapter completion pulse
- grant_o  out  2  debug: 2'b00 none, 2'b01 I-cache, 2'b10 D-cache

## Operation

State machine states: IDLE, GRANT_I, GRANT_D, GAP.

- **IDLE**
  - All adapter_* request outputs are 0 and both resp outputs are 0.
  - A port requests when its read_i | write_i = 1.
  - No request: stay in IDLE.
  - Exactly one port requesting: go to that port's GRANT state.
  - Both requesting: the winner is chosen by the priority rule (see Configuration).
- **GRANT_x**
  - adapter_address_o, adapter_line_o, adapter_read_o and adapter_write_o are driven combinationally from the granted port.
  - If the granted port asserts read and write together, read wins: adapter_write_o = 0.
  - x_resp_o = adapter_resp_i; the other port's resp stays 0.
  - On adapter_resp_i = 1, go to GAP.
  - Request changes from the granted port mid-grant are illegal and are not checked.
- **GAP**
  - Lasts one cycle with all adapter_* request outputs at 0, then go to IDLE.
  - This guarantees the adapter sees no request in the cycle it returns to its own idle state.
- icache_line_o and dcache_line_o both carry adapter_line_i at all times. Only the resp pulse qualifies the data.
- Non-granted request inputs and data inputs are ignored.

Reset:
- reset_n = 0 forces IDLE immediately, asynchronously, including mid-transaction.
- Reset values: all adapter_* request outputs 0, both resp outputs 0, grant_o = 2'b00, round-robin pointer = "last served D-cache".
- The adapter is reset by the same reset_n, so no transaction survives reset.

## Timing
- Grant latency: a request first seen at rising edge N (arbiter in IDLE) → GRANT state from cycle N+1. adapter_read_o or adapter_write_o is 1 during cycle N+1.
- Response: adapter_resp_i and x_resp_o are high in the same cycle (combinational, zero latency).
- Turnaround: resp cycle → GAP cycle → IDLE cycle → earliest next grant is the following cycle. The minimum spacing is 3 cycles from one resp to the next grant's first adapter request cycle.
- A requester that keeps its request high after its resp is treated as a new request when the arbiter reaches IDLE.
- grant_o is registered and matches the current state.

## Configuration
- ARBITER_RR_EN defined: round-robin arbitration.
  - On a simultaneous request, the port not served last wins.
  - The pointer updates on each entry into a GRANT state.
  - The first tie after reset goes to the I-cache.
- Not defined: fixed priority. The D-cache always wins ties, and no pointer register is built.

## Test plan
- Lone I-cache read at 0x0000_1000: adapter_read_o=1 and adapter_address_o=0x0000_1000 one cycle after the request; icache_resp_o pulses with the adapter's resp; dcache_resp_o stays 0; grant_o=01.
- D-cache write of line 0xA5..A5 at 0x8000_0040: adapter_write_o=1 and adapter_line_o=0xA5..A5 during the grant; the GAP cycle has adapter_write_o=0.
- I and D requests in the same IDLE cycle:
  - Without the macro: D-cache served first, then I-cache.
  - With ARBITER_RR_EN: I-cache served first, then D-cache; a second simultaneous pair goes D-cache first.
- D-cache keeps read high for two back-to-back misses: exactly one GAP cycle and one IDLE cycle with adapter_read_o=0 between the two grants.
- One port asserts read and write together: adapter_read_o=1, adapter_write_o=0.
- reset_n pulled low 2 cycles into a D-cache read grant: all outputs drop to 0 asynchronously, grant_o=00. After release, a pending I-cache request is granted normally.
